r16_wb_router: RTL and testbench

- Write-back side of the radix-16 butterfly datapath.
- Accepts one 16-lane result beat per handshake: results y0..y15, memory-address indices MA_idx_out and bank-number indices BN_idx_out.
- Routes each lane to the 16 banked coefficient memories, one write per bank per cycle.
- Serializes bank conflicts, buffers up to two beats, and pulses stage_done after a configured number of beats.

---
 rtl/r16_pkg.sv | 17 +
 rtl/r16_beat_fifo.sv | 38 +++
 rtl/r16_wb_router.sv | 140 ++++++++++++++
 tb/tb_r16_wb_router.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r16_pkg.sv
// Shared types for the radix-16 write-back router: lane and beat layouts.
package r16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int NB     = 16;
  localparam int BN_W   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] ma;
    logic [BN_W-1:0]   bn;
  } lane_t;

  typedef lane_t [NB-1:0] beat_t;

endpackage

// File: rtl/r16_beat_fifo.sv
// Two-entry FIFO of full 16-lane beats feeding the bank arbiter.
module r16_beat_fifo
  import r16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  beat_t      din,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  // Pointer and occupancy bookkeeping; reset drops any buffered beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Beat storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/r16_wb_router.sv
// Routes 16-lane butterfly results to 16 banked memories, serialising bank
// conflicts one grant per bank per cycle and flagging stage completion.
module r16_wb_router
  import r16_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NB*DW-1:0] in_data,
  input  logic [NB*DW-1:0] in_ma,
  input  logic [NB*DW-1:0] in_bn,
  input  logic [15:0]      cfg_beats,
  output logic [NB-1:0]    wr_en,
  output logic [NB*AW-1:0] wr_addr,
  output logic [NB*DW-1:0] wr_data,
  output logic             busy,
  output logic             stage_done
);

  beat_t                 in_beat;
  beat_t                 head;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  push;
  logic                  pop;
  logic [NB-1:0]         pending;
  logic [NB-1:0]         pending_after;
  logic [NB-1:0]         lane_grant;
  logic [NB-1:0]         wr_en_next;
  logic [NB*AW-1:0]      wr_addr_next;
  logic [NB*DW-1:0]      wr_data_next;
  logic                  hit;
  logic [BN_W-1:0]       sel;
  logic [15:0]           beat_cnt;
  logic [15:0]           beat_cnt_inc;
  logic                  stage_hit;
  logic [NB*(DW-AW)-1:0] unused_ma;
  logic [NB*(DW-BN_W)-1:0] unused_bn;

  assign in_ready = rst && (count < 2'd2);
  assign push     = in_valid && in_ready;

  // Slice the flat input buses into lanes, keeping only the low index bits.
  always_comb begin
    in_beat   = '0;
    unused_ma = '0;
    unused_bn = '0;
    for (int i = 0; i < NB; i++) begin
      in_beat[i].data = in_data[i*DW +: DW];
      in_beat[i].ma   = in_ma[i*DW +: AW];
      in_beat[i].bn   = in_bn[i*DW +: BN_W];
      unused_ma[i*(DW-AW) +: (DW-AW)]     = in_ma[i*DW+AW +: (DW-AW)];
      unused_bn[i*(DW-BN_W) +: (DW-BN_W)] = in_bn[i*DW+BN_W +: (DW-BN_W)];
    end
  end

  r16_beat_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_beat),
    .head  (head),
    .count (count)
  );

  // Per bank, grant the lowest-index pending lane that targets it.
  always_comb begin
    lane_grant   = '0;
    wr_en_next   = '0;
    wr_addr_next = '0;
    wr_data_next = '0;
    hit          = 1'b0;
    sel          = '0;
    for (int b = 0; b < NB; b++) begin
      hit = 1'b0;
      sel = '0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (pending[i] && (head[i].bn == BN_W'(b))) begin
          hit = 1'b1;
          sel = BN_W'(i);
        end
      end
      if (hit) begin
        lane_grant[sel]              = 1'b1;
        wr_en_next[b]                = 1'b1;
        wr_addr_next[b*AW +: AW]     = head[sel].ma;
        wr_data_next[b*DW +: DW]     = head[sel].data;
      end
    end
  end

  assign pending_after = pending & ~lane_grant;
  assign pop           = (pending != '0) && (pending_after == '0);
  assign count_next    = count + {1'b0, push} - {1'b0, pop};
  assign beat_cnt_inc  = beat_cnt + 16'd1;
  assign stage_hit     = pop && (cfg_beats != 16'd0) && (beat_cnt_inc == cfg_beats);

  // Pending mask: clear granted lanes, reload whenever a fresh head is waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if ((pending_after == '0) && (count_next != 2'd0)) begin
      pending <= '1;
    end else begin
      pending <= pending_after;
    end
  end

  // Beat counter wraps to zero on the beat that completes a stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= stage_hit ? 16'd0 : beat_cnt_inc;
    end
  end

  // Registered bank write ports and stage pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      stage_done <= 1'b0;
    end else begin
      wr_en      <= wr_en_next;
      wr_addr    <= wr_addr_next;
      wr_data    <= wr_data_next;
      stage_done <= stage_hit;
    end
  end

  assign busy = (count != 2'd0) || (wr_en != '0);

endmodule

// File: tb/tb_r16_wb_router.sv
// Scoreboard bench for r16_wb_router: stimulus queues expected write cycles,
// a negedge monitor pops and compares whenever the router writes.
`timescale 1ns/1ps
module tb_r16_wb_router;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NB = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NB*DW-1:0] in_data = '0;
  logic [NB*DW-1:0] in_ma = '0;
  logic [NB*DW-1:0] in_bn = '0;
  logic [15:0]      cfg_beats = '0;
  logic [NB-1:0]    wr_en;
  logic [NB*AW-1:0] wr_addr;
  logic [NB*DW-1:0] wr_data;
  logic             busy;
  logic             stage_done;

  r16_wb_router #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ma      (in_ma),
    .in_bn      (in_bn),
    .cfg_beats  (cfg_beats),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .stage_done (stage_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0]    en;
    logic [NB*AW-1:0] addr;
    logic [NB*DW-1:0] data;
    logic             done;
    bit               follow;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_out = -10;
  logic [DW-1:0]    lane_data [NB];
  logic [DW-1:0]    lane_ma [NB];
  logic [DW-1:0]    lane_bn [NB];
  logic [NB*AW-1:0] ea;
  logic [NB*DW-1:0] ed;

  // Edge counter: after the n-th rising edge cyc reads n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [NB-1:0] en, input logic [NB*AW-1:0] a,
                         input logic [NB*DW-1:0] d, input logic done, input bit follow);
    exp_t e;
    e.en = en; e.addr = a; e.data = d; e.done = done; e.follow = follow;
    expq.push_back(e);
  endtask

  // Present the lane arrays as a beat and hold it until accepted; k = accept edge.
  task automatic applyStimulus(output int k);
    for (int i = 0; i < NB; i++) begin
      in_data[i*DW +: DW] = lane_data[i];
      in_ma[i*DW +: DW]   = lane_ma[i];
      in_bn[i*DW +: DW]   = lane_bn[i];
    end
    in_valid = 1'b1;
    k = -1;
    for (int w = 0; w < 100 && k < 0; w++) begin
      if (in_ready) k = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (k < 0) checkOutput("accept timeout", 256'd1, 256'd0);
  endtask

  task automatic waitDrain();
    int w = 0;
    while ((expq.size() != 0 || busy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain", {expq.size() != 0, busy}, 256'd0);
  endtask

  // Monitor: every write cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && (wr_en != '0 || stage_done)) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected write", {wr_en, stage_done}, 256'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("wr_en", wr_en, mon_e.en);
        checkOutput("wr_addr", wr_addr, mon_e.addr);
        checkOutput("wr_data", wr_data, mon_e.data);
        checkOutput("stage_done", stage_done, mon_e.done);
        if (mon_e.follow) checkOutput("back-to-back", cyc, last_out + 1);
      end
      last_out = cyc;
    end
  end

  // Global safety net.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ka, kb, kc, k, k0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset in_ready", in_ready, 256'd0);
    checkOutput("reset wr_en", wr_en, 256'd0);
    checkOutput("reset busy", busy, 256'd0);
    checkOutput("reset stage_done", stage_done, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("ready after release", in_ready, 256'd1);
    @(negedge clk);

    // Identity beat, one beat per stage.
    $display("[TB] identity beat");
    cfg_beats = 16'd1;
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = DW'(i); lane_ma[i] = 16'd7; lane_data[i] = DW'(100 + i);
      ea[i*AW +: AW] = AW'(7); ed[i*DW +: DW] = DW'(100 + i);
    end
    pushExp(16'hFFFF, ea, ed, 1'b1, 1'b0);
    applyStimulus(k);
    checkOutput("latency early", wr_en, 256'd0);
    @(negedge clk); #1;
    checkOutput("latency strobe", {wr_en, stage_done}, {16'hFFFF, 1'b1});
    @(negedge clk); #1;
    checkOutput("strobe drop", {wr_en, stage_done}, 256'd0);
    waitDrain();

    // Full conflict on bank 3, then two beats queued behind it.
    $display("[TB] bank 3 conflict");
    cfg_beats = 16'd3;
    for (int i = 0; i < NB; i++) begin
      ea = '0; ed = '0;
      ea[3*AW +: AW] = AW'(i); ed[3*DW +: DW] = DW'(16'h200 + i);
      pushExp(16'h0008, ea, ed, 1'b0, i > 0);
    end
    for (int b = 0; b < NB; b++) begin
      ea[b*AW +: AW] = AW'(20 + b); ed[b*DW +: DW] = DW'(16'h300 + b);
    end
    pushExp(16'hFFFF, ea, ed, 1'b0, 1'b1);
    for (int b = 0; b < NB; b++) begin
      ea[b*AW +: AW] = AW'(30); ed[b*DW +: DW] = DW'(16'h400 + 15 - b);
    end
    pushExp(16'hFFFF, ea, ed, 1'b1, 1'b1);
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = 16'd3; lane_ma[i] = DW'(i); lane_data[i] = DW'(16'h200 + i);
    end
    applyStimulus(ka);
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = DW'(i); lane_ma[i] = DW'(20 + i); lane_data[i] = DW'(16'h300 + i);
    end
    applyStimulus(kb);
    checkOutput("second accept", kb, ka + 1);
    checkOutput("held ready", in_ready, 256'd0);
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = DW'(15 - i); lane_ma[i] = 16'd30; lane_data[i] = DW'(16'h400 + i);
    end
    applyStimulus(kc);
    checkOutput("held until pop", kc, ka + 17);
    waitDrain();

    // Four conflict-free beats forming one stage.
    $display("[TB] four-beat stage");
    cfg_beats = 16'd4;
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < NB; b++) begin
        ea[b*AW +: AW] = AW'(16*j + b); ed[b*DW +: DW] = DW'(16'h500 + 16*j + b);
      end
      pushExp(16'hFFFF, ea, ed, j == 3, j > 0);
    end
    k0 = 0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NB; i++) begin
        lane_bn[i] = DW'(i); lane_ma[i] = DW'(16*j + i); lane_data[i] = DW'(16'h500 + 16*j + i);
      end
      applyStimulus(k);
      if (j == 0) k0 = k;
    end
    checkOutput("back-to-back accepts", k, k0 + 3);
    @(negedge clk); #1;
    checkOutput("final beat done+busy", {stage_done, busy}, 256'd3);
    @(negedge clk); #1;
    checkOutput("busy after stage", {stage_done, busy}, 256'd0);
    waitDrain();

    // Pairs of lanes per bank: lanes 0-7 first, then 8-15.
    $display("[TB] two-way conflict");
    cfg_beats = 16'd0;
    for (int h = 0; h < 2; h++) begin
      ea = '0; ed = '0;
      for (int b = 0; b < 8; b++) begin
        ea[b*AW +: AW] = AW'(40 + 8*h + b); ed[b*DW +: DW] = DW'(16'h600 + 8*h + b);
      end
      pushExp(16'h00FF, ea, ed, 1'b0, h > 0);
    end
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = DW'(i % 8); lane_ma[i] = DW'(40 + i); lane_data[i] = DW'(16'h600 + i);
    end
    applyStimulus(k);
    waitDrain();

    // Upper index bits set: only low bits may matter.
    $display("[TB] high index bits");
    for (int b = 0; b < NB; b++) begin
      ea[b*AW +: AW] = AW'(100 + 15 - b); ed[b*DW +: DW] = DW'(16'h700 + 15 - b);
    end
    pushExp(16'hFFFF, ea, ed, 1'b0, 1'b0);
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = 16'hFFF0 | DW'(15 - i);
      lane_ma[i] = 16'hA800 | DW'(100 + i);
      lane_data[i] = DW'(16'h700 + i);
    end
    applyStimulus(k);
    waitDrain();

    // Reset in the middle of a conflicted beat.
    $display("[TB] reset mid-beat");
    cfg_beats = 16'd2;
    for (int i = 0; i < 3; i++) begin
      ea = '0; ed = '0;
      ea[5*AW +: AW] = AW'(i); ed[5*DW +: DW] = DW'(16'h800 + i);
      pushExp(16'h0020, ea, ed, 1'b0, i > 0);
    end
    for (int i = 0; i < NB; i++) begin
      lane_bn[i] = 16'd5; lane_ma[i] = DW'(i); lane_data[i] = DW'(16'h800 + i);
    end
    applyStimulus(k);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset outputs", {wr_en, wr_addr, stage_done, busy, in_ready}, 256'd0);
    checkOutput("async reset data", wr_data, 256'd0);
    checkOutput("grants before reset", expq.size(), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("ready after reset", in_ready, 256'd1);
    repeat (3) @(negedge clk);
    #1 checkOutput("no stale write", {wr_en, busy}, 256'd0);
    for (int j = 0; j < 2; j++) begin
      for (int b = 0; b < NB; b++) begin
        ea[b*AW +: AW] = AW'(50 + b); ed[b*DW +: DW] = DW'(16'h900 + 16*j + b);
      end
      pushExp(16'hFFFF, ea, ed, j == 1, j > 0);
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NB; i++) begin
        lane_bn[i] = DW'(i); lane_ma[i] = DW'(50 + i); lane_data[i] = DW'(16'h900 + 16*j + i);
      end
      applyStimulus(k);
    end
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
